// File: rtl/muldiv_unit.sv
// ==== muldiv_unit : iterative radix-2 Booth multiply / restoring divide, 32 steps per op ====
// ==== rev 1.0                                                                           ====
`default_nettype none

module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Clear,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] yContents,
   input  logic [WIDTH-1:0] BusMuxOut,
   output logic [WIDTH-1:0] zOutHi,
   output logic [WIDTH-1:0] zOutLo,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int         CNT_W  = $clog2(WIDTH);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_nstate;
   logic             w_busy;
   logic             w_capture;
   logic             w_step;
   logic             w_fix;

   logic             r_op_div;
   logic             r_op_signed;
   logic             r_zero_div;
   logic             r_neg_q;
   logic             r_neg_r;
   logic [WIDTH:0]   r_acc;
   logic [WIDTH-1:0] r_q;
   logic             r_q1;
   logic [WIDTH:0]   r_m;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_done;
   logic             r_dbz;

   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic             w_b_zero;
   logic [WIDTH:0]   w_mul_sum;
   logic [WIDTH:0]   w_div_shift;
   logic [WIDTH+1:0] w_div_diff;
   logic [WIDTH:0]   w_acc_nxt;
   logic [WIDTH-1:0] w_q_nxt;
   logic [WIDTH-1:0] w_res_hi;
   logic [WIDTH-1:0] w_res_lo;

   // ---------------- FSM ----------------
   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) r_state <= S_IDLE;
      else       r_state <= w_nstate;
   end

   always_comb begin
      w_nstate = r_state;
      case (r_state)
         S_IDLE: if (start) w_nstate = (op[0] && w_b_zero) ? S_FIX : S_RUN;
         S_RUN:  if (r_cnt == CNT_W'(WIDTH-1)) w_nstate = S_FIX;
         S_FIX:  w_nstate = S_IDLE;
         default: w_nstate = S_IDLE;
      endcase
   end

   always_comb begin
      w_busy    = (r_state != S_IDLE);
      w_capture = (r_state == S_IDLE) && start;
      w_step    = (r_state == S_RUN);
      w_fix     = (r_state == S_FIX);
   end

   // ---------------- operand conditioning ----------------
   always_comb begin
      w_a_neg  = ~op[1] & yContents[WIDTH-1];
      w_b_neg  = ~op[1] & BusMuxOut[WIDTH-1];
      w_a_mag  = w_a_neg ? -yContents : yContents;
      w_b_mag  = w_b_neg ? -BusMuxOut : BusMuxOut;
      w_b_zero = (BusMuxOut == '0);
   end

   // One iteration: Booth (signed) or shift-add (unsigned) on {acc,q,q1}; restoring step for divide.
   always_comb begin
      w_mul_sum = r_acc;
      if (r_op_signed) begin
         case ({r_q[0], r_q1})
            2'b01:   w_mul_sum = r_acc + r_m;
            2'b10:   w_mul_sum = r_acc - r_m;
            default: w_mul_sum = r_acc;
         endcase
      end else if (r_q[0]) begin
         w_mul_sum = r_acc + r_m;
      end
      w_div_shift = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
      w_div_diff  = {1'b0, w_div_shift} - {1'b0, r_m};
      if (r_op_div) begin
         if (!w_div_diff[WIDTH+1]) begin
            w_acc_nxt = w_div_diff[WIDTH:0];
            w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
         end else begin
            w_acc_nxt = w_div_shift;
            w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         w_acc_nxt = {r_op_signed & w_mul_sum[WIDTH], w_mul_sum[WIDTH:1]};
         w_q_nxt   = {w_mul_sum[0], r_q[WIDTH-1:1]};
      end
   end

   always_comb begin
      w_res_hi = r_acc[WIDTH-1:0];
      w_res_lo = r_q;
      if (r_op_div) begin
         if (r_zero_div) begin
            w_res_hi = r_q;
            w_res_lo = '1;
         end else begin
            w_res_hi = r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
            w_res_lo = r_neg_q ? -r_q : r_q;
         end
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) begin
         r_op_div    <= 1'b0;
         r_op_signed <= 1'b0;
         r_zero_div  <= 1'b0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_acc       <= '0;
         r_q         <= '0;
         r_q1        <= 1'b0;
         r_m         <= '0;
         r_cnt       <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_done      <= 1'b0;
         r_dbz       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_capture) begin
            r_op_div    <= op[0];
            r_op_signed <= ~op[1];
            r_acc       <= '0;
            r_q1        <= 1'b0;
            r_cnt       <= '0;
            r_dbz       <= 1'b0;
            if (op[0]) begin
               // On divide-by-zero the raw dividend rides in r_q straight to the FIX edge.
               r_q        <= w_b_zero ? yContents : w_a_mag;
               r_m        <= {1'b0, w_b_mag};
               r_zero_div <= w_b_zero;
               r_neg_q    <= w_a_neg ^ w_b_neg;
               r_neg_r    <= w_a_neg;
            end else begin
               r_q        <= BusMuxOut;
               r_m        <= {~op[1] & yContents[WIDTH-1], yContents};
               r_zero_div <= 1'b0;
               r_neg_q    <= 1'b0;
               r_neg_r    <= 1'b0;
            end
         end else if (w_step) begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
            r_q1  <= r_q[0];
            r_cnt <= r_cnt + 1'b1;
         end else if (w_fix) begin
            r_hi   <= w_res_hi;
            r_lo   <= w_res_lo;
            r_done <= 1'b1;
            r_dbz  <= r_zero_div;
         end
      end
   end

   assign zOutHi      = r_hi;
   assign zOutLo      = r_lo;
   assign busy        = w_busy;
   assign done        = r_done;
   assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ==== tb_muldiv_unit : scoreboard bench for muldiv_unit, directed vectors ====
`default_nettype none

module tb_muldiv_unit;

   logic        Clock = 1'b0;
   logic        Clear = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] yContents = '0;
   logic [31:0] BusMuxOut = '0;
   logic [31:0] zOutHi;
   logic [31:0] zOutLo;
   logic        busy;
   logic        done;
   logic        div_by_zero;

   localparam logic [1:0] MUL = 2'b00, DIV = 2'b01, MULU = 2'b10, DIVU = 2'b11;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cycle = 0;
   int   tests = 0;
   int   fails = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .Clock(Clock), .Clear(Clear), .start(start), .op(op),
      .yContents(yContents), .BusMuxOut(BusMuxOut),
      .zOutHi(zOutHi), .zOutLo(zOutLo), .busy(busy), .done(done),
      .div_by_zero(div_by_zero)
   );

   always #5 Clock = ~Clock;
   always @(posedge Clock) cycle <= cycle + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Monitor: pops one expectation per done pulse.
   always @(negedge Clock) begin
      if (!Clear && done) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got done=1, expected no pending op (cycle %0d)", cycle);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("zOutHi", zOutHi, e.hi);
            chk("zOutLo", zOutLo, e.lo);
            chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
            chk("latency", cycle, e.cyc);
            chk("busy_at_done", {31'b0, busy}, 32'd0);
         end
      end
   end

   // Called at a negedge; drives start for one cycle and returns at the next negedge.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed,
                        input bit push);
      exp_t e;
      start     = 1'b1;
      op        = o;
      yContents = a;
      BusMuxOut = b;
      if (push) begin
         e.hi  = eh;
         e.lo  = el;
         e.dbz = ed;
         e.cyc = cycle + ((o[0] && b == 32'd0) ? 2 : 34);
         sb.push_back(e);
      end
      @(negedge Clock);
      start     = 1'b0;
      yContents = 32'hDEADBEEF;
      BusMuxOut = 32'h0BADF00D;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge Clock);
         n++;
      end
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL wait_done: got %0d pending, expected 0 after 100 cycles", sb.size());
         sb.delete();
      end
      @(negedge Clock);
   endtask

   task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eh, input logic [31:0] el, input logic ed);
      @(negedge Clock);
      issue(o, a, b, eh, el, ed, 1'b1);
      wait_idle();
   endtask

   initial begin
      #1 Clock = 1'b0;
      #6;
      chk("reset_hi",   zOutHi, 32'd0);
      chk("reset_lo",   zOutLo, 32'd0);
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_done", {31'b0, done}, 32'd0);
      chk("reset_dbz",  {31'b0, div_by_zero}, 32'd0);
      repeat (2) @(negedge Clock);
      Clear = 1'b0;

      // MUL 7 * -3 with busy / hold-off checks
      @(negedge Clock);
      issue(MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b1);
      chk("busy_after_E0", {31'b0, busy}, 32'd1);
      repeat (31) @(negedge Clock);
      chk("busy_E32", {31'b0, busy}, 32'd1);
      chk("hold_hi_E32", zOutHi, 32'd0);
      chk("hold_lo_E32", zOutLo, 32'd0);
      @(negedge Clock);
      chk("busy_E33_pending", {31'b0, busy}, 32'd1);
      chk("no_done_before_E33", {31'b0, done}, 32'd0);
      wait_idle();

      run(DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      run(DIV,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
      run(DIVU, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 1'b0);
      run(MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
      run(MUL,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
      run(DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
      run(MULU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0);
      run(DIVU, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0);

      // divide by zero, sticky flag, then cleared by the next op
      run(DIV, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1);
      chk("dbz_sticky", {31'b0, div_by_zero}, 32'd1);
      @(negedge Clock);
      issue(MUL, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b1);
      chk("dbz_cleared_at_start", {31'b0, div_by_zero}, 32'd0);
      wait_idle();
      run(DIV,  32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);
      run(DIVU, 32'd3,        32'd0, 32'd3,        32'hFFFFFFFF, 1'b1);

      // second start during busy is ignored
      @(negedge Clock);
      issue(MUL, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 1'b0 == 1'b1 ? 1'b0 : 1'b1);
      repeat (4) @(negedge Clock);
      start = 1'b1; op = MULU; yContents = 32'd5; BusMuxOut = 32'd5;
      @(negedge Clock);
      start = 1'b0;
      wait_idle();

      // back-to-back: start in the done cycle
      @(negedge Clock);
      issue(DIVU, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0, 1'b1);
      begin
         int n = 0;
         while (!done && n < 60) begin
            @(negedge Clock);
            n++;
         end
         chk("b2b_done_seen", {31'b0, done}, 32'd1);
      end
      issue(MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b1);
      chk("b2b_busy", {31'b0, busy}, 32'd1);
      wait_idle();

      // asynchronous Clear mid-operation
      @(negedge Clock);
      issue(MUL, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0, 1'b1);
      repeat (9) @(negedge Clock);
      #2 Clear = 1'b1;
      sb.delete();
      #1;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      chk("abort_hi",   zOutHi, 32'd0);
      chk("abort_lo",   zOutLo, 32'd0);
      repeat (2) @(negedge Clock);
      Clear = 1'b0;
      repeat (40) @(negedge Clock);
      chk("abort_idle", {31'b0, busy}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Sequential 32-bit multiply/divide engine feeding the datapath's 64-bit Z pair (zHI/zLO).
- Operand A comes from the Y register and operand B from the bus. Operands are captured on start.
- Multiply uses radix-2 Booth; divide uses restoring division. Both are iterative, one bit per cycle.
- Results are held on zOutHi/zOutLo until the next operation or reset, so control can pulse zHighin/zLowin after done.

Parameters:
- WIDTH, 32, operand width; results are 2*WIDTH split Hi/Lo. All tests use 32.

Ports:
- Clock  in  1  system clock, rising edge
- Clear  in  1  asynchronous active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  2  00=MUL signed, 01=DIV signed, 10=MULU, 11=DIVU
- yContents  in  WIDTH  operand A (multiplicand / dividend)
- BusMuxOut  in  WIDTH  operand B (multiplier / divisor)
- zOutHi  out  WIDTH  MUL: product[63:32]; DIV: remainder
- zOutLo  out  WIDTH  MUL: product[31:0]; DIV: quotient
- busy  out  1  high from capture edge until done edge
- done  out  1  one-cycle pulse, results valid
- div_by_zero  out  1  sticky until next accepted start

Behaviour:
- Reset (Clear=1, asynchronous): state=IDLE; zOutHi=zOutLo=0; busy=done=div_by_zero=0; iteration counter=0.
- Clear mid-operation aborts the operation. No done pulse is generated and the partial result is discarded.
- States and transitions:
  - IDLE -> CAPTURE: start=1 at a rising edge (E0).
  - At E0: latch op, yContents, BusMuxOut. Clear div_by_zero. Set busy=1. Counter=0.
  - At E0, for a divide with divisor==0: go straight to FIX.
  - All other cases: RUN.
  - RUN: one iteration per edge, E1..E32. Counter increments; after the edge where counter==WIDTH-1, next state is FIX.
  - FIX (edge E33, or E1 for divide-by-zero): apply sign correction and register zOutHi/zOutLo. done=1 for exactly one cycle, busy=0, state=IDLE.
- Latency:
  - Normal operation: done is high in the cycle following E33.
  - Divide-by-zero: done is high in the cycle following E1.
- start while busy=1: ignored, no queuing.
- start in the cycle done is high: accepted, since the state is already IDLE; back-to-back operation is legal.
- Operand inputs after E0 are don't-care.
- zOutHi/zOutLo do not change during RUN; they update only at the FIX edge.
- Signed MUL: full 64-bit two's-complement product via Booth with arithmetic right shift of {A_acc, Q, q-1}. -2^31 * -2^31 = 0x40000000_00000000 (no overflow).
- MULU: 64-bit unsigned product. Implement via a zero-extended Booth or shift-add path; the result must be exact.
- Signed DIV:
  - Divide magnitudes unsigned, then fix signs in FIX.
  - Quotient truncates toward zero and is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Invariant: dividend = q*divisor + r, with |r| < |divisor|.
  - -2^31 / -1: quotient=0x80000000 (wraps), remainder=0, div_by_zero=0.
- DIVU: plain unsigned quotient/remainder.
- Divide-by-zero (signed or unsigned): div_by_zero=1, zOutLo=0xFFFFFFFF, zOutHi=dividend unchanged.
- MUL ops never set div_by_zero.

Test Plan:
- MUL 7 * 0xFFFFFFFD (-3), start at E0 -> busy high through E33; done after E33; zOutHi=0xFFFFFFFF, zOutLo=0xFFFFFFEB; outputs unchanged before E33.
- DIV 0xFFFFFFF9 (-7) / 2 -> zOutLo=0xFFFFFFFD (-3), zOutHi=0xFFFFFFFF (-1). Also DIV 7 / 0xFFFFFFFE -> zOutLo=0xFFFFFFFD, zOutHi=0x00000001.
- DIVU 0xFFFFFFFF / 0x10 -> zOutLo=0x0FFFFFFF, zOutHi=0x0000000F. Also MULU 0xFFFFFFFF * 0xFFFFFFFF -> zOutHi=0xFFFFFFFE, zOutLo=0x00000001.
- Corner cases:
  - MUL 0x80000000 * 0x80000000 -> zOutHi=0x40000000, zOutLo=0.
  - DIV 0x80000000 / 0xFFFFFFFF -> zOutLo=0x80000000, zOutHi=0.
- DIV 5 / 0 -> done after E1; div_by_zero=1, zOutHi=5, zOutLo=0xFFFFFFFF. A following MUL 2*3 clears div_by_zero and gives zOutLo=6.
- Abort and handshake:
  - MUL started, second start pulsed at E5 with different operands -> ignored; first result correct.
  - New op started, Clear asserted asynchronously mid-cycle at E10 -> busy, done, and outputs go to 0 immediately; no done pulse follows.
  - Start asserted in the done cycle -> the new op completes 33 edges later.
